ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset)

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_sync_edge.sv | 54 +++++
 rtl/ps2_host_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types, command constants and helpers for the host transmitter
// (and the keyboard receiver once it is rewritten).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    FAIL      = 3'd6
  } tx_state_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_START = 2'b01,
    ERR_XFER  = 2'b10,
    ERR_NOACK = 2'b11
  } ps2_err_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings one raw open-drain PS/2 line into the clock domain: 2-FF synchroniser,
// stability filter on the synchronised level, and a one-cycle fall pulse.
module ps2_sync_edge #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic sync_o,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // Idle bus level is high, so the reset values avoid a spurious fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign sync_o  = sync_q[1];
  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device clock falls, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       psClk_in,
  input  logic       psData_in,
  output logic       psClk_oe,
  output logic       psData_oe,
  output logic       done,
  output logic [1:0] err
);

  localparam int unsigned TMAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned IW   = $clog2(INHIBIT_CYCLES + 1);

  tx_state_t     state_q, state_d;
  logic [8:0]    frame_q, frame_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    idx_q, idx_d;
  logic          bit_oe_q, bit_oe_d;
  ps2_err_t      code_q, code_d;
  logic          done_q, done_d;
  ps2_err_t      err_q, err_d;

  logic clk_sync, clk_fall, dat_sync;
  logic clk_level_unused, dat_level_unused, dat_fall_unused;
  logic clk_oe, dat_oe, xfer_phase, xfer_expired;

  ps2_sync_edge #(.FILTER_LEN(FILTER_LEN)) u_clk_line (
    .clk     (Clk),
    .rst_n   (Reset),
    .line_i  (psClk_in),
    .sync_o  (clk_sync),
    .level_o (clk_level_unused),
    .fall_o  (clk_fall)
  );

  ps2_sync_edge #(.FILTER_LEN(FILTER_LEN)) u_dat_line (
    .clk     (Clk),
    .rst_n   (Reset),
    .line_i  (psData_in),
    .sync_o  (dat_sync),
    .level_o (dat_level_unused),
    .fall_o  (dat_fall_unused)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      inh_q    <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      bit_oe_q <= 1'b0;
      code_q   <= ERR_OK;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      inh_q    <= inh_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      bit_oe_q <= bit_oe_d;
      code_q   <= code_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign xfer_phase   = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
  assign xfer_expired = (timer_q == TW'(XFER_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    inh_d    = inh_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    bit_oe_d = bit_oe_q;
    code_d   = code_q;
    done_d   = 1'b0;
    err_d    = err_q;
    clk_oe   = 1'b0;
    dat_oe   = 1'b0;

    if (xfer_phase) timer_d = timer_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          frame_d = {odd_parity(tx_data), tx_data};
          inh_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe = 1'b1;
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          dat_oe  = 1'b1;
          timer_d = '0;
          state_d = RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      RTS: begin
        dat_oe = 1'b1;
        if (clk_fall) begin
          // The fall that ends RTS is the first SEND fall: bit 0 goes out now,
          // which puts the device ACK on the 11th fall.
          timer_d  = '0;
          bit_oe_d = ~frame_q[0];
          idx_d    = 4'd1;
          state_d  = SEND;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          code_d  = ERR_START;
          state_d = FAIL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SEND: begin
        dat_oe = bit_oe_q;
        if (xfer_expired) begin
          code_d  = ERR_XFER;
          state_d = FAIL;
        end else if (clk_fall) begin
          if (idx_q == 4'd9) begin
            bit_oe_d = 1'b0;
            state_d  = ACK;
          end else begin
            bit_oe_d = ~frame_q[idx_q];
            idx_d    = idx_q + 4'd1;
          end
        end
      end
      ACK: begin
        if (xfer_expired) begin
          code_d  = ERR_XFER;
          state_d = FAIL;
        end else if (clk_fall) begin
          if (!dat_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            code_d  = ERR_NOACK;
            state_d = FAIL;
          end
        end
      end
      WAIT_IDLE: begin
        if (xfer_expired) begin
          code_d  = ERR_XFER;
          state_d = FAIL;
        end else if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          err_d   = ERR_OK;
          state_d = IDLE;
        end
      end
      FAIL: begin
        done_d  = 1'b1;
        err_d   = code_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = ~tx_ready;
  assign psClk_oe  = clk_oe;
  assign psData_oe = dat_oe;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on a wired-AND bus.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 50;
  localparam int unsigned ST   = 300;
  localparam int unsigned XT   = 600;
  localparam int unsigned FL   = 4;
  localparam int unsigned HALF = 20;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, psClk_oe, psData_oe, done;
  logic [1:0] err;
  logic       bfm_clk = 1'b1;
  logic       bfm_data = 1'b1;
  logic       ps_clk, ps_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned done_cnt = 0;
  logic [1:0]  last_err = 2'b00;
  int unsigned inh_run = 0, last_inh = 0, inh_runs = 0;
  int unsigned rts_run = 0, last_rts = 0;

  assign ps_clk  = psClk_oe  ? 1'b0 : bfm_clk;
  assign ps_data = psData_oe ? 1'b0 : bfm_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST),
    .XFER_TIMEOUT   (XT),
    .FILTER_LEN     (FL)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .psClk_in  (ps_clk),
    .psData_in (ps_data),
    .psClk_oe  (psClk_oe),
    .psData_oe (psData_oe),
    .done      (done),
    .err       (err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (psClk_oe) inh_run <= inh_run + 1;
    else begin
      if (inh_run != 0) begin
        last_inh <= inh_run;
        inh_runs <= inh_runs + 1;
      end
      inh_run <= 0;
    end
    if (psData_oe && !psClk_oe) rts_run <= rts_run + 1;
    else begin
      if (rts_run != 0) last_rts <= rts_run;
      rts_run <= 0;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      last_err <= err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge Clk);
    #1 tx_data = d;
    tx_valid = 1'b1;
    @(posedge Clk);
    #1 tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, then clock up to n_falls falls,
  // sampling psData on each rising edge. Fall 11 is the ACK slot.
  task automatic bfm_frame(input int unsigned n_falls, input bit ack_low,
                           output logic [9:0] cap, output logic start_bit, output bit found);
    int unsigned t;
    cap = '1;
    start_bit = 1'b1;
    t = 0;
    while (!(ps_clk === 1'b1 && ps_data === 1'b0) && t < 2000) begin
      @(negedge Clk);
      t++;
    end
    found = (t < 2000);
    if (!found) return;
    repeat (5) @(negedge Clk);
    start_bit = ps_data;
    for (int unsigned k = 1; k <= n_falls && k <= 10; k++) begin
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge Clk);
      bfm_clk = 1'b1;
      cap[k-1] = ps_data;
      repeat (HALF) @(negedge Clk);
    end
    if (n_falls >= 11) begin
      if (ack_low) bfm_data = 1'b0;
      repeat (HALF / 2) @(negedge Clk);
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge Clk);
      bfm_clk = 1'b1;
      repeat (HALF / 2) @(negedge Clk);
      bfm_data = 1'b1;
      repeat (HALF / 2) @(negedge Clk);
    end
  endtask

  task automatic wait_done(input int unsigned base, input int unsigned limit, input string tag);
    int unsigned t;
    t = 0;
    while (done_cnt == base && t < limit) begin
      @(negedge Clk);
      t++;
    end
    @(negedge Clk);
    chk(tag, done_cnt - base, 1);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input string tag);
    logic [9:0]  cap;
    logic        sb;
    bit          found;
    int unsigned base;
    base = done_cnt;
    send(d);
    tx_data = ~d;
    bfm_frame(11, 1'b1, cap, sb, found);
    chk({tag, "_rts"}, 32'(found), 1);
    chk({tag, "_start"}, 32'(sb), 0);
    chk({tag, "_data"}, 32'(cap[7:0]), 32'(d));
    chk({tag, "_par"}, 32'(cap[8]), 32'(par));
    chk({tag, "_stop"}, 32'(cap[9]), 1);
    wait_done(base, 1000, {tag, "_done"});
    chk({tag, "_err"}, 32'(last_err), 0);
  endtask

  initial begin
    logic [9:0]  cap;
    logic        sb;
    bit          found;
    int unsigned base, ibase;

    repeat (3) @(negedge Clk);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clk_oe", 32'(psClk_oe), 0);
    chk("rst_dat_oe", 32'(psData_oe), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);

    // 1: set-LEDs, bits 1,0,1,1,0,1,1,1 parity 1
    run_frame(8'hED, 1'b1, "t1");
    chk("t1_inhibit_len", last_inh, INH);

    // 2: parity corners
    run_frame(8'h01, 1'b0, "t2a");
    run_frame(8'h00, 1'b1, "t2b");
    run_frame(8'hFF, 1'b1, "t2c");

    // 3: device never clocks
    base = done_cnt;
    send(8'hF4);
    bfm_frame(0, 1'b1, cap, sb, found);
    chk("t3_rts", 32'(found), 1);
    wait_done(base, 1000, "t3_done");
    chk("t3_err", 32'(last_err), 1);
    chk("t3_rts_len", last_rts, ST);
    chk("t3_clk_oe", 32'(psClk_oe), 0);
    chk("t3_dat_oe", 32'(psData_oe), 0);

    // 4: device stops after four falls, then a clean retry
    base = done_cnt;
    send(8'h01);
    bfm_frame(4, 1'b1, cap, sb, found);
    wait_done(base, 2000, "t4_done");
    chk("t4_err", 32'(last_err), 2);
    chk("t4_clk_oe", 32'(psClk_oe), 0);
    chk("t4_dat_oe", 32'(psData_oe), 0);
    run_frame(8'hF4, 1'b0, "t4b");

    // 5: no ACK
    base = done_cnt;
    send(8'hED);
    bfm_frame(11, 1'b0, cap, sb, found);
    wait_done(base, 1000, "t5_done");
    chk("t5_err", 32'(last_err), 3);

    // 6: async reset at idx 5 (bit 4 of 0xED is 0, so psData is driven)
    send(8'hED);
    bfm_frame(5, 1'b1, cap, sb, found);
    #2;
    chk("t6_busy_pre", 32'(busy), 1);
    chk("t6_dat_oe_pre", 32'(psData_oe), 1);
    Reset = 1'b0;
    #1;
    chk("t6_clk_oe_rst", 32'(psClk_oe), 0);
    chk("t6_dat_oe_rst", 32'(psData_oe), 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("t6_ready", 32'(tx_ready), 1);
    base = done_cnt;
    ibase = inh_runs;
    send(8'hFF);
    repeat (10) @(negedge Clk);
    chk("t6_busy", 32'(busy), 1);
    send(8'h00);
    bfm_frame(11, 1'b1, cap, sb, found);
    chk("t6_data", 32'(cap[7:0]), 32'hFF);
    chk("t6_par", 32'(cap[8]), 1);
    wait_done(base, 1000, "t6_done");
    chk("t6_err", 32'(last_err), 0);
    repeat (300) @(negedge Clk);
    chk("t6_one_done", done_cnt - base, 1);
    chk("t6_one_frame", inh_runs - ibase, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
